// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/mem/writeback.
// Define MC_ADDI_EN to add the addi path (states ADDIEX/ADDIWB).
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
`ifdef MC_ADDI_EN
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
`else
        JUMP   = 4'd9
`endif
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        state      = state_q;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                unique case (1'b1)
                    (op == OP_LW),
                    (op == OP_SW):   state_d = MEMADR;
                    (op == OP_R):    state_d = EXEC;
                    (op == OP_BEQ):  state_d = BRANCH;
                    (op == OP_J):    state_d = JUMP;
`ifdef MC_ADDI_EN
                    (op == OP_ADDI): state_d = ADDIEX;
`endif
                    default:         illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
`ifdef MC_ADDI_EN
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
`endif
            default: state = 4'd0;
        endcase
        // Reset kills strobes and writes combinationally, not at the next edge.
        if (!rst_n) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            pc_src     = 2'b00;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            illegal_op = 1'b0;
            state      = 4'd0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm.
// Inputs change 1ns after posedge; outputs are checked 2ns after posedge.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       illegal_op;
    logic [3:0] state;
    logic [19:0] outs;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read),
        .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
    );

    assign outs = {mem_read, mem_write, iord, ir_write, pc_en,
                   pc_src, reg_write, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, alu_op, illegal_op, state};

    // Leaves the DUT in FETCH at posedge+1.
    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; op = 6'b000000; zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            nchk++;
            if (outs !== 20'h0) begin
                nerr++;
                $display("FAIL reset_outs cyc%0d got=%h exp=0", i, outs);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1; #1;
        nchk++;
        if ({state, mem_read, alu_src_b, ir_write, pc_en, iord}
            !== {4'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL reset_release st=%0d rd=%b srcb=%b irw=%b pce=%b iord=%b",
                     state, mem_read, alu_src_b, ir_write, pc_en, iord);
        end
    endtask

    task automatic test_lw();
        logic [3:0] s1 [5] = '{0, 1, 2, 3, 4};
        logic [3:0] s2 [7] = '{0, 1, 2, 3, 3, 3, 4};
        do_reset();
        op = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            nchk++;
            if ({state, reg_write, mem_to_reg} !== {s1[i], i == 4, i == 4}) begin
                nerr++;
                $display("FAIL lw cyc%0d st=%0d rw=%b m2r=%b exp_st=%0d",
                         i, state, reg_write, mem_to_reg, s1[i]);
            end
            next_cycle();
        end
        for (int i = 0; i < 7; i++) begin
            mem_ready = !(i == 3 || i == 4);
            #1;
            nchk++;
            if (state !== s2[i]) begin
                nerr++;
                $display("FAIL lw_wait_state cyc%0d got=%0d exp=%0d", i, state, s2[i]);
            end
            if (i >= 3 && i <= 5) begin
                nchk++;
                if ({mem_read, iord} !== 2'b11) begin
                    nerr++;
                    $display("FAIL lw_wait_strobe cyc%0d rd=%b iord=%b exp=11",
                             i, mem_read, iord);
                end
            end
            next_cycle();
        end
        mem_ready = 1'b1; #1;
        nchk++;
        if (state !== 4'd0) begin
            nerr++;
            $display("FAIL lw_wait_end got=%0d exp=0", state);
        end
    endtask

    task automatic test_rtype();
        logic [3:0] s [5] = '{0, 1, 6, 7, 0};
        do_reset();
        op = 6'b000000; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            nchk++;
            if (state !== s[i]) begin
                nerr++;
                $display("FAIL rtype_state cyc%0d got=%0d exp=%0d", i, state, s[i]);
            end
            if (i == 2) begin
                nchk++;
                if ({alu_op, alu_src_a, alu_src_b} !== 5'b10_1_00) begin
                    nerr++;
                    $display("FAIL rtype_exec aluop=%b srca=%b srcb=%b",
                             alu_op, alu_src_a, alu_src_b);
                end
            end
            if (i == 3) begin
                nchk++;
                if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
                    nerr++;
                    $display("FAIL rtype_wb rw=%b dst=%b m2r=%b exp=110",
                             reg_write, reg_dst, mem_to_reg);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_sw();
        logic [3:0] s [5] = '{0, 1, 2, 5, 0};
        logic any_rw = 1'b0;
        do_reset();
        op = 6'b101011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            any_rw |= reg_write;
            nchk++;
            if ({state, mem_write} !== {s[i], i == 3}) begin
                nerr++;
                $display("FAIL sw cyc%0d st=%0d mw=%b exp_st=%0d",
                         i, state, mem_write, s[i]);
            end
            next_cycle();
        end
        nchk++;
        if (any_rw !== 1'b0) begin
            nerr++;
            $display("FAIL sw_no_regwrite got=%b exp=0", any_rw);
        end
    endtask

    task automatic test_beq();
        logic [3:0] s [4] = '{0, 1, 8, 0};
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            op = 6'b000100; mem_ready = 1'b1; zero = z[0];
            for (int i = 0; i < 4; i++) begin
                #1;
                nchk++;
                if (state !== s[i]) begin
                    nerr++;
                    $display("FAIL beq_state z=%0d cyc%0d got=%0d exp=%0d",
                             z, i, state, s[i]);
                end
                if (i == 2) begin
                    nchk++;
                    if ({pc_en, pc_src, alu_op} !== {z[0], 2'b01, 2'b01}) begin
                        nerr++;
                        $display("FAIL beq_branch z=%0d pce=%b src=%b aluop=%b",
                                 z, pc_en, pc_src, alu_op);
                    end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_jump();
        logic [3:0] s [4] = '{0, 1, 9, 0};
        do_reset();
        op = 6'b000010; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            nchk++;
            if (state !== s[i]) begin
                nerr++;
                $display("FAIL jump_state cyc%0d got=%0d exp=%0d", i, state, s[i]);
            end
            if (i == 2) begin
                nchk++;
                if ({pc_en, pc_src} !== 3'b1_10) begin
                    nerr++;
                    $display("FAIL jump_pc pce=%b src=%b exp=1 10", pc_en, pc_src);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_illegal();
        logic [3:0] s [4] = '{0, 1, 0, 1};
        do_reset();
        op = 6'b111111; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            nchk++;
            if ({state, illegal_op} !== {s[i], s[i] == 4'd1}) begin
                nerr++;
                $display("FAIL illegal cyc%0d st=%0d ill=%b exp_st=%0d",
                         i, state, illegal_op, s[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_addi();
`ifdef MC_ADDI_EN
        logic [3:0] s [5] = '{0, 1, 10, 11, 0};
        do_reset();
        op = 6'b001000; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            nchk++;
            if ({state, illegal_op, reg_write} !== {s[i], 1'b0, i == 3}) begin
                nerr++;
                $display("FAIL addi cyc%0d st=%0d ill=%b rw=%b exp_st=%0d",
                         i, state, illegal_op, reg_write, s[i]);
            end
            next_cycle();
        end
`else
        logic [3:0] s [3] = '{0, 1, 0};
        do_reset();
        op = 6'b001000; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nchk++;
            if ({state, illegal_op} !== {s[i], i == 1}) begin
                nerr++;
                $display("FAIL addi_illegal cyc%0d st=%0d ill=%b exp_st=%0d",
                         i, state, illegal_op, s[i]);
            end
            next_cycle();
        end
`endif
    endtask

    task automatic test_reset_midwr();
        do_reset();
        op = 6'b101011; mem_ready = 1'b1;
        repeat (3) next_cycle();
        mem_ready = 1'b0; #1;
        nchk++;
        if ({state, mem_write} !== {4'd5, 1'b1}) begin
            nerr++;
            $display("FAIL midwr_pre st=%0d mw=%b exp=5 1", state, mem_write);
        end
        rst_n = 1'b0; #1;
        nchk++;
        if (outs !== 20'h0) begin
            nerr++;
            $display("FAIL midwr_drop got=%h exp=0", outs);
        end
        next_cycle();
        rst_n = 1'b1; #1;
        nchk++;
        if ({state, mem_read, mem_write} !== {4'd0, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL midwr_after st=%0d rd=%b mw=%b exp=0 1 0",
                     state, mem_read, mem_write);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_sw();
        test_beq();
        test_jump();
        test_illegal();
        test_addi();
        test_reset_midwr();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
